ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives both lines open-drain and paces each bit off device clock falls.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, START, DATA, PARITY, STOP, WAIT_IDLE
   } state_t;

   state_t        state, state_nx;
   logic [1:0]    clk_sync, data_sync;
   logic          prev_clk, sync_clk, sync_data, fall;
   logic [7:0]    shreg, shreg_nx;
   logic          par, par_nx;
   logic [3:0]    bit_cnt, bit_cnt_nx;
   logic [IW-1:0] inh_cnt, inh_cnt_nx;
   logic [TW-1:0] to_cnt;
   logic          to_run, to_hit;
   logic          clk_oe_c, data_oe_c;

   assign sync_clk  = clk_sync[1];
   assign sync_data = data_sync[1];
   assign fall      = prev_clk & ~sync_clk;

   // Two-flop synchronizers plus previous-clock register for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         prev_clk  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         prev_clk  <= sync_clk;
      end
   end

   assign to_run = state inside {START, DATA, PARITY, STOP, WAIT_IDLE};
   assign to_hit = to_run && (to_cnt == TO_MAX);

   // Watchdog: cycles since the last device fall while the device owns timing.
   always_ff @(posedge clk) begin
      if (rst || !to_run || fall)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         par     <= 1'b0;
         bit_cnt <= '0;
         inh_cnt <= '0;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         par     <= par_nx;
         bit_cnt <= bit_cnt_nx;
         inh_cnt <= inh_cnt_nx;
      end
   end

   // Next state, line drive and done/err pulses.
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      par_nx     = par;
      bit_cnt_nx = bit_cnt;
      inh_cnt_nx = inh_cnt;
      clk_oe_c   = 1'b0;
      data_oe_c  = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_valid) begin
               shreg_nx   = tx_data;
               par_nx     = ~^tx_data;
               inh_cnt_nx = '0;
               state_nx   = INHIBIT;
            end
         end
         INHIBIT: begin
            clk_oe_c = 1'b1;
            if (inh_cnt == INH_LAST)
               state_nx = START;
            else
               inh_cnt_nx = inh_cnt + 1'b1;
         end
         START: begin
            data_oe_c = 1'b1;
            if (fall) begin
               bit_cnt_nx = 4'd1;
               state_nx   = DATA;
            end else if (to_hit) begin
               data_oe_c = 1'b0;
               err       = 1'b1;
               state_nx  = IDLE;
            end
         end
         DATA: begin
            data_oe_c = ~shreg[0];
            if (fall) begin
               if (bit_cnt == 4'd8) begin
                  state_nx = PARITY;
               end else begin
                  shreg_nx   = {1'b0, shreg[7:1]};
                  bit_cnt_nx = bit_cnt + 1'b1;
               end
            end else if (to_hit) begin
               data_oe_c = 1'b0;
               err       = 1'b1;
               state_nx  = IDLE;
            end
         end
         PARITY: begin
            data_oe_c = ~par;
            if (fall) begin
               state_nx = STOP;
            end else if (to_hit) begin
               data_oe_c = 1'b0;
               err       = 1'b1;
               state_nx  = IDLE;
            end
         end
         STOP: begin
            if (fall) begin
               if (!sync_data) begin
                  state_nx = WAIT_IDLE;
               end else begin
                  err      = 1'b1;
                  state_nx = IDLE;
               end
            end else if (to_hit) begin
               err      = 1'b1;
               state_nx = IDLE;
            end
         end
         WAIT_IDLE: begin
            if (sync_clk && sync_data) begin
               done     = 1'b1;
               state_nx = IDLE;
            end else if (to_hit) begin
               err      = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign tx_ready    = (state == IDLE);
   assign busy        = (state != IDLE);
   assign ps2_clk_oe  = clk_oe_c & ~rst;
   assign ps2_data_oe = data_oe_c & ~rst;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model.
// Vector table for whole frames plus sequences for timeout, handshake, reset.
module tb_ps2_host_tx;

   localparam int INH = 100;
   localparam int TO  = 300;
   localparam int H   = 20;

   typedef struct {
      logic [7:0]  d;
      bit          ack;
      logic [10:0] fr;
      int          ndone;
      int          nerr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, busy, done, err;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk, ps2_data;

   assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data = ~(ps2_data_oe | dev_data_low);

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_done = 0;
   int n_err = 0;
   int viol = 0;
   int last_done = -1;
   logic [7:0] acc_q[$];
   int acc_cyc[$];

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy),
      .done(done),
      .err(err),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   // Cycle counter, pulse counters, accept log and invariant watch.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) begin
         n_done <= n_done + 1;
         last_done <= cyc;
      end
      if (err)
         n_err <= n_err + 1;
      viol <= viol + int'(done && err) + int'(tx_ready == busy)
            + int'(ps2_clk_oe && ps2_data_oe);
      if (tx_valid && tx_ready && !rst) begin
         acc_q.push_back(tx_data);
         acc_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Device: wait out inhibit, then clock nf falls, sampling mid-high.
   task automatic dev_frame(input int nf, input bit ack,
                            output logic [10:0] fr, output int inh);
      int n = 0;
      fr  = '0;
      inh = 0;
      while (!ps2_clk_oe && n < 1000) begin
         @(negedge clk);
         n++;
      end
      while (ps2_clk_oe && n < 1000) begin
         @(negedge clk);
         n++;
         inh++;
      end
      if (n >= 1000) begin
         chk("dev_wait", n, 0);
         return;
      end
      for (int i = 0; i < nf; i++) begin
         repeat (H) @(negedge clk);
         if (i < 11)
            fr[i] = ps2_data;
         if (i == 10 && ack) begin
            dev_data_low = 1'b1;
            @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         dev_clk_low = 1'b0;
      end
      repeat (H) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   initial begin : main
      logic [10:0] fr;
      int inh, d0, e0, n, t0, t1, a0;
      vec_t v[4];

      v[0] = '{8'hF4, 1'b1, 11'b1_0_1111_0100_0, 1, 0};
      v[1] = '{8'hED, 1'b1, 11'b1_1_1110_1101_0, 1, 0};
      v[2] = '{8'h00, 1'b1, 11'b1_1_0000_0000_0, 1, 0};
      v[3] = '{8'h07, 1'b0, 11'b1_0_0000_0111_0, 0, 1};

      repeat (3) @(negedge clk);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 4; k++) begin
         d0 = n_done;
         e0 = n_err;
         send(v[k].d);
         dev_frame(11, v[k].ack, fr, inh);
         repeat (10) @(negedge clk);
         chk($sformatf("frame%0d", k), 32'(fr), 32'(v[k].fr));
         chk($sformatf("inhibit%0d", k), inh, INH);
         chk($sformatf("done%0d", k), n_done - d0, v[k].ndone);
         chk($sformatf("err%0d", k), n_err - e0, v[k].nerr);
         chk($sformatf("ready%0d", k), tx_ready, 1);
         chk($sformatf("clk_oe%0d", k), ps2_clk_oe, 0);
         chk($sformatf("data_oe%0d", k), ps2_data_oe, 0);
      end

      d0 = n_done;
      e0 = n_err;
      send(8'hF4);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         @(negedge clk);
         n++;
      end
      t0 = cyc;
      n = 0;
      while (!err && n < 2 * TO) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      chk("to_delay", t1 - t0, TO);
      chk("to_clk_oe", ps2_clk_oe, 0);
      chk("to_data_oe", ps2_data_oe, 0);
      @(negedge clk);
      chk("to_ready", tx_ready, 1);
      chk("to_err_cnt", n_err - e0, 1);
      chk("to_done_cnt", n_done - d0, 0);

      a0 = acc_q.size();
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'hAA;
      dev_frame(11, 1'b1, fr, inh);
      chk("hs_frame55", 32'(fr), 32'(11'b1_1_0101_0101_0));
      n = 0;
      while (acc_q.size() < a0 + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      chk("hs_accepts", acc_q.size(), a0 + 2);
      if (acc_q.size() >= a0 + 2) begin
         chk("hs_first", acc_q[a0], 8'h55);
         chk("hs_second", acc_q[a0+1], 8'hAA);
         chk("hs_timing", acc_cyc[a0+1], last_done + 1);
      end
      d0 = n_done;
      dev_frame(11, 1'b1, fr, inh);
      repeat (10) @(negedge clk);
      chk("hs_frameAA", 32'(fr), 32'(11'b1_1_1010_1010_0));
      chk("hs_doneAA", n_done - d0, 1);

      send(8'h07);
      dev_frame(4, 1'b0, fr, inh);
      chk("mid_bits", 32'(fr[3:0]), 32'(4'b1110));
      chk("mid_busy", busy, 1);
      chk("mid_data_oe", ps2_data_oe, 1);
      rst = 1'b1;
      #1;
      chk("mid_rel_clk", ps2_clk_oe, 0);
      chk("mid_rel_data", ps2_data_oe, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_busy0", busy, 0);
      chk("mid_ready", tx_ready, 1);
      chk("mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 0);
      d0 = n_done;
      e0 = n_err;
      send(8'hF4);
      dev_frame(11, 1'b1, fr, inh);
      repeat (10) @(negedge clk);
      chk("post_frame", 32'(fr), 32'(11'b1_0_1111_0100_0));
      chk("post_done", n_done - d0, 1);
      chk("post_err", n_err - e0, 0);
      chk("post_ready", tx_ready, 1);

      chk("invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
